// File: rtl/lsu_wb.sv
// Load/store + writeback stage: one instruction per EX handshake, req/ack memory bus, registered RF write port.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN; otherwise misaligned addresses are forced aligned.
module lsu_wb #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic              ex_wreg_i,
    input  logic [REG_AW-1:0] ex_wd_i,
    input  logic [XLEN-1:0]   ex_wdata_i,
    input  logic [3:0]        ex_memop_i,
    input  logic [XLEN-1:0]   ex_sdata_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              we_o,
    output logic [REG_AW-1:0] wd_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic              misalign_o
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [3:0] OP_LB  = 4'h1;
    localparam logic [3:0] OP_LH  = 4'h2;
    localparam logic [3:0] OP_LW  = 4'h3;
    localparam logic [3:0] OP_LBU = 4'h4;
    localparam logic [3:0] OP_LHU = 4'h5;
    localparam logic [3:0] OP_SB  = 4'h9;
    localparam logic [3:0] OP_SH  = 4'hA;
    localparam logic [3:0] OP_SW  = 4'hB;

    logic [0:0]        state;
    logic [3:0]        op_q;
    logic [REG_AW-1:0] wd_q;

    logic              is_load;
    logic              is_store;
    logic              size_half;
    logic              size_word;
    logic              misaligned;
    logic [XLEN-1:0]   eff_addr;
    logic [3:0]        be;
    logic [XLEN-1:0]   store_data;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [XLEN-1:0]   load_data;
    logic              accept;

    assign ex_ready_o = (state == IDLE) && !rst;
    assign accept     = ex_valid_i && ex_ready_o;

    // Unknown op codes fall through with all flags clear and behave as NONE.
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        size_half = 1'b0;
        size_word = 1'b0;
        case (ex_memop_i)
            OP_LB, OP_LBU: is_load = 1'b1;
            OP_LH, OP_LHU: begin is_load = 1'b1; size_half = 1'b1; end
            OP_LW:         begin is_load = 1'b1; size_word = 1'b1; end
            OP_SB:         is_store = 1'b1;
            OP_SH:         begin is_store = 1'b1; size_half = 1'b1; end
            OP_SW:         begin is_store = 1'b1; size_word = 1'b1; end
            default:       ;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = (size_half && ex_wdata_i[0]) || (size_word && (ex_wdata_i[1:0] != 2'b00));
    assign eff_addr   = ex_wdata_i;
`else
    // Without the trap, low address bits below the access size are simply dropped.
    assign misaligned = 1'b0;
    assign eff_addr   = {ex_wdata_i[XLEN-1:2],
                         ex_wdata_i[1] & ~size_word,
                         ex_wdata_i[0] & ~(size_word | size_half)};
`endif

    always_comb begin
        if (size_word) begin
            be         = 4'b1111;
            store_data = ex_sdata_i;
        end else if (size_half) begin
            be         = eff_addr[1] ? 4'b1100 : 4'b0011;
            store_data = {(XLEN/16){ex_sdata_i[15:0]}};
        end else begin
            be         = 4'b0001 << eff_addr[1:0];
            store_data = {(XLEN/8){ex_sdata_i[7:0]}};
        end
    end

    // Lane selection uses the latched bus address so it matches the request in flight.
    always_comb begin
        case (mem_addr_o[1:0])
            2'd0:    byte_sel = mem_rdata_i[7:0];
            2'd1:    byte_sel = mem_rdata_i[15:8];
            2'd2:    byte_sel = mem_rdata_i[23:16];
            default: byte_sel = mem_rdata_i[31:24];
        endcase
        half_sel = mem_addr_o[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (op_q)
            OP_LB:   load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
            OP_LH:   load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {{(XLEN-16){1'b0}}, half_sel};
            default: load_data = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= 4'h0;
            wd_q        <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= 4'h0;
            mem_wdata_o <= '0;
            we_o        <= 1'b0;
            wd_o        <= '0;
            wdata_o     <= '0;
            misalign_o  <= 1'b0;
        end else begin
            we_o       <= 1'b0;
            misalign_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!(is_load || is_store)) begin
                            we_o    <= ex_wreg_i && (ex_wd_i != '0);
                            wd_o    <= ex_wd_i;
                            wdata_o <= ex_wdata_i;
                        end else if (misaligned) begin
                            misalign_o <= 1'b1;
                        end else begin
                            state       <= BUSY;
                            op_q        <= ex_memop_i;
                            wd_q        <= ex_wd_i;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= is_store;
                            mem_addr_o  <= eff_addr;
                            mem_be_o    <= be;
                            mem_wdata_o <= store_data;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        state     <= IDLE;
                        mem_req_o <= 1'b0;
                        if (!mem_we_o) begin
                            we_o    <= (wd_q != '0);
                            wd_o    <= wd_q;
                            wdata_o <= load_data;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_wb.sv
// Self-checking bench for lsu_wb: directed scenarios plus randomized ops against an arithmetic reference model.
module tb_lsu_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic        ex_wreg_i;
    logic [4:0]  ex_wd_i;
    logic [31:0] ex_wdata_i;
    logic [3:0]  ex_memop_i;
    logic [31:0] ex_sdata_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        we_o;
    logic [4:0]  wd_o;
    logic [31:0] wdata_o;
    logic        misalign_o;

    int passed = 0;
    int total  = 0;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    lsu_wb #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_wreg_i(ex_wreg_i),
        .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_memop_i(ex_memop_i), .ex_sdata_i(ex_sdata_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .we_o(we_o), .wd_o(wd_o), .wdata_o(wdata_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    // Access size in bytes; 0 means the op does not touch memory.
    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'h1, 4'h4, 4'h9: return 1;
            4'h2, 4'h5, 4'hA: return 2;
            4'h3, 4'hB:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic bit op_is_load(input logic [3:0] op);
        return (op >= 4'h1) && (op <= 4'h5);
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr,
                                                input logic [31:0] rdata);
        int sz;
        logic [31:0] val;
        logic [31:0] mask;
        sz   = op_size(op);
        if (sz == 4) return rdata;
        mask = (sz == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        val  = (rdata >> ((addr % 4) * 8)) & mask;
        if ((op == 4'h1 || op == 4'h2) && (val > (mask >> 1))) val = val | ~mask;
        return val;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One complete instruction: handshake, optional bus transaction with 'waits' stall cycles, writeback check.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [4:0] wd,
                                 input logic wreg, input logic [31:0] sdata, input logic [31:0] rdata,
                                 input int waits);
        int sz;
        bit load;
        logic [31:0] eaddr;
        logic [31:0] exp_wdata;
        sz    = op_size(op);
        load  = op_is_load(op);
        eaddr = (sz == 0) ? addr : addr - (addr % sz);
        @(negedge clk);
        ex_valid_i = 1'b1; ex_memop_i = op; ex_wdata_i = addr; ex_wd_i = wd;
        ex_wreg_i = wreg; ex_sdata_i = sdata;
        checkOutput("ready_idle", {31'd0, ex_ready_o}, 32'd1);
        @(posedge clk); #1;
        ex_valid_i = 1'b0;
        @(negedge clk);
        if (sz == 0) begin
            checkOutput("alu_we", {31'd0, we_o}, {31'd0, wreg && (wd != 0)});
            checkOutput("alu_wd", {27'd0, wd_o}, {27'd0, wd});
            checkOutput("alu_wdata", wdata_o, addr);
        end else if (TRAP && (addr % sz) != 0) begin
            checkOutput("mis_pulse", {31'd0, misalign_o}, 32'd1);
            checkOutput("mis_noreq", {31'd0, mem_req_o}, 32'd0);
            checkOutput("mis_ready", {31'd0, ex_ready_o}, 32'd1);
            @(negedge clk);
            checkOutput("mis_once", {31'd0, misalign_o}, 32'd0);
            checkOutput("mis_nowe", {31'd0, we_o}, 32'd0);
        end else begin
            checkOutput("req", {31'd0, mem_req_o}, 32'd1);
            checkOutput("req_we", {31'd0, mem_we_o}, {31'd0, !load});
            checkOutput("req_addr", mem_addr_o, eaddr);
            checkOutput("req_be", {28'd0, mem_be_o}, ((32'd1 << sz) - 1) << (eaddr % 4));
            if (!load) begin
                exp_wdata = (sz == 1) ? (sdata & 32'hFF) * 32'h0101_0101 :
                            (sz == 2) ? (sdata & 32'hFFFF) * 32'h0001_0001 : sdata;
                checkOutput("req_wdata", mem_wdata_o, exp_wdata);
            end
            checkOutput("busy_ready", {31'd0, ex_ready_o}, 32'd0);
            for (int i = 0; i < waits; i++) begin
                @(negedge clk);
                checkOutput("hold_req", {31'd0, mem_req_o}, 32'd1);
                checkOutput("hold_addr", mem_addr_o, eaddr);
                checkOutput("hold_ready", {31'd0, ex_ready_o}, 32'd0);
                checkOutput("hold_nowe", {31'd0, we_o}, 32'd0);
            end
            mem_ack_i = 1'b1; mem_rdata_i = rdata;
            @(posedge clk); #1;
            mem_ack_i = 1'b0; mem_rdata_i = $urandom;
            @(negedge clk);
            checkOutput("wb_we", {31'd0, we_o}, {31'd0, load && (wd != 0)});
            if (load && wd != 0) begin
                checkOutput("wb_wd", {27'd0, wd_o}, {27'd0, wd});
                checkOutput("wb_data", wdata_o, model_load(op, eaddr, rdata));
            end
            checkOutput("ack_req_low", {31'd0, mem_req_o}, 32'd0);
            checkOutput("ack_ready", {31'd0, ex_ready_o}, 32'd1);
            @(negedge clk);
            checkOutput("we_once", {31'd0, we_o}, 32'd0);
        end
    endtask

    initial begin
        logic [3:0] ops [11];
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h9, 4'hA, 4'hB, 4'h6, 4'hC};
        rst = 1'b1; ex_valid_i = 1'b0; ex_wreg_i = 1'b0; ex_wd_i = '0; ex_wdata_i = '0;
        ex_memop_i = '0; ex_sdata_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", {31'd0, ex_ready_o}, 32'd0);
        checkOutput("rst_req", {31'd0, mem_req_o}, 32'd0);
        checkOutput("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
        checkOutput("rst_addr", mem_addr_o, 32'd0);
        checkOutput("rst_be", {28'd0, mem_be_o}, 32'd0);
        checkOutput("rst_mwdata", mem_wdata_o, 32'd0);
        checkOutput("rst_we", {31'd0, we_o}, 32'd0);
        checkOutput("rst_wd", {27'd0, wd_o}, 32'd0);
        checkOutput("rst_wdata", wdata_o, 32'd0);
        checkOutput("rst_mis", {31'd0, misalign_o}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ready", {31'd0, ex_ready_o}, 32'd1);

        // ALU burst: back-to-back NONE ops, last one to x0
        ex_valid_i = 1'b1; ex_memop_i = 4'h0; ex_wreg_i = 1'b1; ex_wd_i = 5'd1; ex_wdata_i = 32'h11;
        @(posedge clk); #1; ex_wd_i = 5'd2; ex_wdata_i = 32'h22;
        @(negedge clk);
        checkOutput("burst1_we", {31'd0, we_o}, 32'd1);
        checkOutput("burst1_wd", {27'd0, wd_o}, 32'd1);
        checkOutput("burst1_data", wdata_o, 32'h11);
        @(posedge clk); #1; ex_wd_i = 5'd3; ex_wdata_i = 32'h33;
        @(negedge clk);
        checkOutput("burst2_we", {31'd0, we_o}, 32'd1);
        checkOutput("burst2_wd", {27'd0, wd_o}, 32'd2);
        checkOutput("burst2_data", wdata_o, 32'h22);
        @(posedge clk); #1; ex_wd_i = 5'd0; ex_wdata_i = 32'h44;
        @(negedge clk);
        checkOutput("burst3_we", {31'd0, we_o}, 32'd1);
        checkOutput("burst3_wd", {27'd0, wd_o}, 32'd3);
        checkOutput("burst3_data", wdata_o, 32'h33);
        @(posedge clk); #1; ex_valid_i = 1'b0;
        @(negedge clk);
        checkOutput("burst_x0_we", {31'd0, we_o}, 32'd0);

        // Directed memory scenarios
        applyStimulus(4'h1, 32'h0000_1003, 5'd4, 1'b1, 32'h0, 32'h80FF_FF7F, 0);
        applyStimulus(4'h4, 32'h0000_1003, 5'd4, 1'b1, 32'h0, 32'h80FF_FF7F, 0);
        applyStimulus(4'hA, 32'h0000_2002, 5'd6, 1'b0, 32'h0000_ABCD, 32'h0, 3);
        applyStimulus(4'h3, 32'h0000_3001, 5'd7, 1'b1, 32'h0, 32'hDEAD_BEEF, 1);
        applyStimulus(4'h2, 32'h0000_3002, 5'd0, 1'b1, 32'h0, 32'h8001_7FFF, 0);

        // Reset in the second BUSY cycle of an LW, followed by a stray ack
        @(negedge clk);
        ex_valid_i = 1'b1; ex_memop_i = 4'h3; ex_wdata_i = 32'h0000_4000; ex_wd_i = 5'd9; ex_wreg_i = 1'b1;
        @(posedge clk); #1; ex_valid_i = 1'b0;
        @(negedge clk);
        checkOutput("rb_req", {31'd0, mem_req_o}, 32'd1);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        checkOutput("rb_ready_in_rst", {31'd0, ex_ready_o}, 32'd0);
        @(posedge clk); #1; rst = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        @(negedge clk);
        checkOutput("rb_req_dropped", {31'd0, mem_req_o}, 32'd0);
        checkOutput("rb_ready", {31'd0, ex_ready_o}, 32'd1);
        @(posedge clk); #1; mem_ack_i = 1'b0;
        @(negedge clk);
        checkOutput("rb_no_we", {31'd0, we_o}, 32'd0);
        @(negedge clk);
        checkOutput("rb_no_we2", {31'd0, we_o}, 32'd0);

        // Randomized ops against the reference model
        for (int n = 0; n < 60; n++) begin
            applyStimulus(ops[$urandom_range(0, 10)], $urandom, 5'($urandom_range(0, 31)),
                          1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
